// File: rtl/battle_pkg.sv
// Shared battle-screen encodings used by the phase controller, player_sprite and renderer.
package battle_pkg;

  localparam int unsigned HP_MAX = 3;
  localparam int unsigned HP_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DODGE    = 2'd1,
    ST_ACT      = 2'd2,
    ST_GAMEOVER = 2'd3
  } state_e;

endpackage

// File: rtl/battle_phase_ctrl_tick_divider.sv
// Modulo-N counter with enable and clear; tc_o flags the enabled cycle that wraps the count.
module tick_divider #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/battle_phase_ctrl.sv
// Battle phase sequencer: game state, sprite move pacing, HP ownership and hit debouncing.
module battle_phase_ctrl
  import battle_pkg::state_e, battle_pkg::ST_IDLE, battle_pkg::ST_DODGE,
         battle_pkg::ST_ACT, battle_pkg::ST_GAMEOVER;
#(
  parameter int unsigned MOVE_DIV      = 1_000_000,
  parameter int unsigned IFRAME_FRAMES = 60,
  parameter int unsigned DODGE_FRAMES  = 600,
  parameter int unsigned HP_MAX        = battle_pkg::HP_MAX,
  parameter int unsigned HP_W          = battle_pkg::HP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            frame_tick,
  input  logic            collision,
  output logic [1:0]      state,
  output logic            move_en,
  output logic [HP_W-1:0] hp,
  output logic            invuln,
  output logic            blink,
  output logic            hit
);

  localparam logic [HP_W-1:0] HP_LOAD = HP_W'(HP_MAX);
  localparam logic [HP_W-1:0] HP_ONE  = HP_W'(1);

  state_e          state_q, state_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic            invuln_q, invuln_d;
  logic            blink_q, blink_d;
  logic            hit_q, hit_d;
  logic            move_en_q, move_en_d;

  logic in_dodge, damage;
  logic move_tc, phase_tc, iframe_tc, blink_tc;

  assign in_dodge = (state_q == ST_DODGE);
  assign damage   = in_dodge && !invuln_q && collision && (hp_q != '0);

  // Holding clear outside DODGE restarts the move and phase counts on every entry.
  tick_divider #(.N(MOVE_DIV)) u_move_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (in_dodge),
    .clr_i (!in_dodge),
    .tc_o  (move_tc)
  );

  tick_divider #(.N(DODGE_FRAMES)) u_phase_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (in_dodge && frame_tick),
    .clr_i (!in_dodge),
    .tc_o  (phase_tc)
  );

  tick_divider #(.N(IFRAME_FRAMES)) u_iframe_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (invuln_q && frame_tick),
    .clr_i (!invuln_q),
    .tc_o  (iframe_tc)
  );

  tick_divider #(.N(4)) u_blink_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (invuln_q && frame_tick),
    .clr_i (!invuln_q),
    .tc_o  (blink_tc)
  );

  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    invuln_d = invuln_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DODGE;
          hp_d    = HP_LOAD;
        end
      end
      ST_DODGE: begin
        if (damage) begin
          hp_d     = hp_q - HP_ONE;
          invuln_d = 1'b1;
        end
        if (iframe_tc) begin
          invuln_d = 1'b0;
        end
        // A fatal hit outranks the phase timeout in the same cycle.
        if (damage && (hp_q == HP_ONE)) begin
          state_d = ST_GAMEOVER;
        end else if (phase_tc) begin
          state_d = ST_ACT;
        end
      end
      ST_ACT: begin
        if (start) begin
          state_d = ST_DODGE;
        end
      end
      ST_GAMEOVER: begin
        if (start) begin
          state_d = ST_IDLE;
          hp_d    = HP_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != ST_DODGE) begin
      invuln_d = 1'b0;
    end

    hit_d     = damage;
    move_en_d = move_tc && (state_d == ST_DODGE);
    blink_d   = invuln_d ? (blink_tc ? !blink_q : blink_q) : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hp_q      <= HP_LOAD;
      invuln_q  <= 1'b0;
      blink_q   <= 1'b1;
      hit_q     <= 1'b0;
      move_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      invuln_q  <= invuln_d;
      blink_q   <= blink_d;
      hit_q     <= hit_d;
      move_en_q <= move_en_d;
    end
  end

  assign state   = state_q;
  assign hp      = hp_q;
  assign invuln  = invuln_q;
  assign blink   = blink_q;
  assign hit     = hit_q;
  assign move_en = move_en_q;

endmodule

// File: tb/tb_battle_phase_ctrl.sv
// Directed self-checking bench for battle_phase_ctrl using small timing parameters.
module tb_battle_phase_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       frame_tick;
  logic       collision;
  logic [1:0] state,  state2;
  logic       move_en, move_en2;
  logic [1:0] hp,     hp2;
  logic       invuln, invuln2;
  logic       blink,  blink2;
  logic       hit,    hit2;

  int checks = 0;
  int errors = 0;

  battle_phase_ctrl #(
    .MOVE_DIV      (4),
    .IFRAME_FRAMES (3),
    .DODGE_FRAMES  (5),
    .HP_MAX        (3),
    .HP_W          (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame_tick (frame_tick),
    .collision  (collision),
    .state      (state),
    .move_en    (move_en),
    .hp         (hp),
    .invuln     (invuln),
    .blink      (blink),
    .hit        (hit)
  );

  // Long invulnerability window so the blink toggling is observable.
  battle_phase_ctrl #(
    .MOVE_DIV      (4),
    .IFRAME_FRAMES (10),
    .DODGE_FRAMES  (100),
    .HP_MAX        (3),
    .HP_W          (2)
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame_tick (frame_tick),
    .collision  (collision),
    .state      (state2),
    .move_en    (move_en2),
    .hp         (hp2),
    .invuln     (invuln2),
    .blink      (blink2),
    .hit        (hit2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s, f, c;
    logic [1:0] st, hp;
    logic       inv, blk, hit, mv;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t v(input logic s, input logic f, input logic c,
                             input logic [1:0] st, input logic [1:0] hpv,
                             input logic inv, input logic blk,
                             input logic ht, input logic mv);
    vec_t r;
    r.s = s; r.f = f; r.c = c; r.st = st; r.hp = hpv;
    r.inv = inv; r.blk = blk; r.hit = ht; r.mv = mv;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic f, input logic c);
    start = s; frame_tick = f; collision = c;
    @(posedge clk); #1;
    start = 1'b0; frame_tick = 1'b0; collision = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int st, input int hpv,
                         input int inv, input int blk, input int ht, input int mv);
    chk({tag, "_state"},   int'(state),   st);
    chk({tag, "_hp"},      int'(hp),      hpv);
    chk({tag, "_invuln"},  int'(invuln),  inv);
    chk({tag, "_blink"},   int'(blink),   blk);
    chk({tag, "_hit"},     int'(hit),     ht);
    chk({tag, "_move_en"}, int'(move_en), mv);
  endtask

  initial begin
    int hits;
    rst_n = 1'b0; start = 1'b0; frame_tick = 1'b0; collision = 1'b0;

    //           s     f     c     st    hp    inv   blk   hit   mv
    tbl[0]  = v(1'b1, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[1]  = v(1'b0, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[2]  = v(1'b0, 1'b0, 1'b1, 2'd1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[3]  = v(1'b0, 1'b0, 1'b1, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[4]  = v(1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[5]  = v(1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[6]  = v(1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[7]  = v(1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[8]  = v(1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    tbl[9]  = v(1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[10] = v(1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[11] = v(1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[12] = v(1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[13] = v(1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[14] = v(1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[15] = v(1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[16] = v(1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 3, 0, 1, 0, 0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("post_reset", 0, 3, 0, 1, 0, 0);

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].s, tbl[i].f, tbl[i].c);
      chk_all($sformatf("vec%0d", i), int'(tbl[i].st), int'(tbl[i].hp),
              int'(tbl[i].inv), int'(tbl[i].blk), int'(tbl[i].hit), int'(tbl[i].mv));
    end

    // Held collision costs one HP; separated hits run HP down to GAMEOVER.
    cyc(1'b1, 1'b0, 1'b0);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (hit) hits++;
    end
    chk("hold_hits", hits, 1);
    chk("hold_hp", int'(hp), 2);
    chk("hold_invuln", int'(invuln), 1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("iframe2_invuln", int'(invuln), 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("iframe3_invuln", int'(invuln), 0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("hit2_hp", int'(hp), 1);
    chk("hit2_hit", int'(hit), 1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("timeout_state", int'(state), 2);
    chk("timeout_invuln", int'(invuln), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("redodge_state", int'(state), 1);
    chk("redodge_hp", int'(hp), 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("fatal_hp", int'(hp), 0);
    chk("fatal_state", int'(state), 3);
    chk("fatal_hit", int'(hit), 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("restart_state", int'(state), 0);
    chk("restart_hp", int'(hp), 3);

    // Asynchronous reset while in DODGE with hp=1 and invulnerable.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("pre_rst_hp", int'(hp), 1);
    chk("pre_rst_invuln", int'(invuln), 1);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 3, 0, 1, 0, 0);
    @(posedge clk); #1;
    chk_all("held_rst", 0, 3, 0, 1, 0, 0);
    rst_n = 1'b1;

    // Collision coincident with the final phase frame_tick at hp=2.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("coin_pre_invuln", int'(invuln), 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("coin_pre_state", int'(state), 1);
    cyc(1'b0, 1'b1, 1'b1);
    chk_all("coincident", 2, 1, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk($sformatf("act_move_en%0d", i), int'(move_en), 0);
    end

    // Blink on the long-window instance: toggles every 4th frame_tick.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("b_hit", int'(hit2), 1);
    chk("b_start_blink", int'(blink2), 1);
    for (int k = 1; k <= 10; k++) begin
      int exp_blk;
      cyc(1'b0, 1'b1, 1'b0);
      exp_blk = (k == 10) ? 1 : (((k / 4) % 2 == 0) ? 1 : 0);
      chk($sformatf("b_tick%0d_blink", k), int'(blink2), exp_blk);
      chk($sformatf("b_tick%0d_invuln", k), int'(invuln2), (k == 10) ? 0 : 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
